// File: rtl/blit_pkg.sv
// Shared definitions for the blitter Gouraud/Z stepper: lane width, FSM states
// and the lane-slice offset helper.
package blit_pkg;

    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int lane_lo(input int lane);
        return lane * LANE_W;
    endfunction

endpackage

// File: rtl/gstep_lane.sv
// One 16-bit lane of the phrase adder: carry chain split at bits 8 and 12 so
// eight-bit mode and high-carry-inhibit can cut it, with optional clamping.
module gstep_lane
    import blit_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sat,
    input  logic              eightbit,
    input  logic              hicinh,
    output logic [LANE_W-1:0] r,
    output logic              satflag
);

    logic [8:0] lo_s;
    logic [4:0] mid_s;
    logic [4:0] hi_s;
    logic       cin8;
    logic       cin12;
    logic       top;
    logic       btop;

    assign lo_s  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
    assign cin8  = lo_s[8] & ~eightbit;
    assign mid_s = {1'b0, a[11:8]} + {1'b0, b[11:8]} + {4'b0, cin8};
    assign cin12 = mid_s[4] & ~hicinh;
    assign hi_s  = {1'b0, a[15:12]} + {1'b0, b[15:12]} + {4'b0, cin12};

    // Carry out disagreeing with the increment sign means the lane wrapped.
    assign top     = eightbit ? lo_s[8] : hi_s[4];
    assign btop    = eightbit ? b[7] : b[15];
    assign satflag = sat & (btop ^ top);

    assign r[7:0]  = satflag ? {8{top}} : lo_s[7:0];
    assign r[15:8] = (satflag & ~eightbit) ? {8{top}} : {hi_s[3:0], mid_s[3:0]};

endmodule

// File: rtl/gouraud_stepper.sv
// Four-lane phrase accumulator emitting acc, acc+inc, ... through a valid/ready
// register. Define SAT_FLAG_EN to add the per-lane sticky sat_hit output.
//
// state | meaning
// IDLE  | loads accepted, waiting for start
// RUN   | emitting phrases, stepping acc on each handshake
// DONE  | one-cycle done pulse, then back to IDLE
module gouraud_stepper
    import blit_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 10
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    load_acc,
    input  logic                    load_inc,
    input  logic [16*LANES-1:0]     load_data,
    input  logic                    start,
    input  logic [CNT_W-1:0]        count,
    input  logic                    sat,
    input  logic                    eightbit,
    input  logic                    hicinh,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*LANES-1:0]     out_data,
    output logic                    done
`ifdef SAT_FLAG_EN
    ,
    output logic [LANES-1:0]        sat_hit
`endif
);

    localparam int DW = LANES * LANE_W;

    state_e           state_q, state_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [DW-1:0]    inc_q, inc_d;
    logic [DW-1:0]    out_q, out_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             msat_q, msat_d;
    logic             meb_q, meb_d;
    logic             mhc_q, mhc_d;

    logic             idle;
    logic             use_sat, use_eb, use_hc;
    logic             step_en;
    logic [DW-1:0]    step_r;
    logic [LANES-1:0] lane_sat;

    assign idle = (state_q == IDLE);

    // The step taken on the start cycle already obeys the modes being sampled.
    assign use_sat = idle ? sat      : msat_q;
    assign use_eb  = idle ? eightbit : meb_q;
    assign use_hc  = idle ? hicinh   : mhc_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int LO = lane_lo(i);
        gstep_lane u_lane (
            .a        (acc_q[LO +: LANE_W]),
            .b        (inc_q[LO +: LANE_W]),
            .sat      (use_sat),
            .eightbit (use_eb),
            .hicinh   (use_hc),
            .r        (step_r[LO +: LANE_W]),
`ifdef SAT_FLAG_EN
            .satflag  (lane_sat[i])
`else
            .satflag  ()
`endif
        );
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        inc_d   = inc_q;
        out_d   = out_q;
        vld_d   = vld_q;
        rem_d   = rem_q;
        msat_d  = msat_q;
        meb_d   = meb_q;
        mhc_d   = mhc_q;
        step_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_acc) acc_d = load_data;
                if (load_inc) inc_d = load_data;
                if (start) begin
                    msat_d = sat;
                    meb_d  = eightbit;
                    mhc_d  = hicinh;
                    if (count != '0) begin
                        out_d   = acc_q;
                        vld_d   = 1'b1;
                        acc_d   = step_r;
                        rem_d   = count - CNT_W'(1);
                        step_en = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (vld_q && out_ready) begin
                    if (rem_q != '0) begin
                        out_d   = acc_q;
                        acc_d   = step_r;
                        rem_d   = rem_q - CNT_W'(1);
                        step_en = 1'b1;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            inc_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            rem_q   <= '0;
            msat_q  <= 1'b0;
            meb_q   <= 1'b0;
            mhc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            rem_q   <= rem_d;
            msat_q  <= msat_d;
            meb_q   <= meb_d;
            mhc_q   <= mhc_d;
        end
    end

`ifdef SAT_FLAG_EN
    logic [LANES-1:0] sat_hit_q, sat_hit_d;
    logic [LANES-1:0] new_hits;

    always_comb begin
        new_hits  = step_en ? lane_sat : '0;
        sat_hit_d = (idle && start) ? new_hits : (sat_hit_q | new_hits);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) sat_hit_q <= '0;
        else       sat_hit_q <= sat_hit_d;
    end

    assign sat_hit = sat_hit_q;
`endif

    assign busy      = ~idle;
    assign done      = (state_q == DONE);
    assign out_valid = vld_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_gouraud_stepper.sv
// Scoreboard bench for gouraud_stepper: expected phrases are queued when a run
// is launched and compared on every output handshake.
module tb_gouraud_stepper;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        load_acc, load_inc;
    logic [63:0] load_data;
    logic        start;
    logic [9:0]  count;
    logic        sat, eightbit, hicinh;
    logic        busy, out_valid, out_ready, done;
    logic [63:0] out_data;
`ifdef SAT_FLAG_EN
    logic [3:0]  sat_hit;
`endif

    gouraud_stepper #(.LANES(4), .CNT_W(10)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .load_acc  (load_acc),
        .load_inc  (load_inc),
        .load_data (load_data),
        .start     (start),
        .count     (count),
        .sat       (sat),
        .eightbit  (eightbit),
        .hicinh    (hicinh),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .done      (done)
`ifdef SAT_FLAG_EN
        ,
        .sat_hit   (sat_hit)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs_cnt, done_cnt, last_hs, done_cyc, start_cyc;
    bit          valid_seen;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ph(input logic [15:0] v);
        return {48'h0, v};
    endfunction

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (out_valid && out_ready) begin
            hs_cnt++;
            last_hs = cyc;
            if (exp_q.size() == 0) chk("extra_phrase", out_data, 64'hx);
            else chk("phrase", out_data, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) valid_seen = 1'b1;
    end

    task automatic start_run(input logic [63:0] a, input logic [63:0] i, input int cnt,
                             input bit s, input bit eb, input bit hc, input bit do_acc);
        if (do_acc) begin
            @(posedge sys_clk); #1;
            load_acc  = 1'b1;
            load_data = a;
        end
        @(posedge sys_clk); #1;
        load_acc  = 1'b0;
        load_inc  = 1'b1;
        load_data = i;
        @(posedge sys_clk); #1;
        load_inc   = 1'b0;
        start      = 1'b1;
        count      = 10'(cnt);
        sat        = s;
        eightbit   = eb;
        hicinh     = hc;
        start_cyc  = cyc;
        hs_cnt     = 0;
        done_cnt   = 0;
        valid_seen = 1'b0;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int tmo);
        int k = 0;
        while (done_cnt == 0 && k < tmo) begin
            @(posedge sys_clk);
            k++;
        end
        if (done_cnt == 0) chk("done_timeout", 0, 1);
        #1;
    endtask

    task automatic run(input logic [63:0] a, input logic [63:0] i, input int cnt,
                       input bit s, input bit eb, input bit hc);
        start_run(a, i, cnt, s, eb, hc, 1'b1);
        wait_done(100);
        chk("hs_count", 64'(hs_cnt), 64'(cnt));
        chk("queue_empty", 64'(exp_q.size()), 0);
    endtask

    initial begin
        reset     = 1'b1;
        load_acc  = 1'b0;
        load_inc  = 1'b0;
        load_data = '0;
        start     = 1'b0;
        count     = '0;
        sat       = 1'b0;
        eightbit  = 1'b0;
        hicinh    = 1'b0;
        out_ready = 1'b1;
        hs_cnt    = 0;
        done_cnt  = 0;
        last_hs   = 0;
        done_cyc  = 0;
        start_cyc = 0;
        valid_seen = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        reset = 1'b0;

        // basic stepping and done latency
        exp_q.push_back(ph(16'h1000));
        exp_q.push_back(ph(16'h1010));
        exp_q.push_back(ph(16'h1020));
        run(ph(16'h1000), ph(16'h0010), 3, 0, 0, 0);
        chk("done_latency", 64'(done_cyc - last_hs), 1);

        exp_q.push_back(ph(16'hFFF0));
        exp_q.push_back(ph(16'hFFFF));
        run(ph(16'hFFF0), ph(16'h0020), 2, 1, 0, 0);

        exp_q.push_back(ph(16'hFFF0));
        exp_q.push_back(ph(16'h0010));
        run(ph(16'hFFF0), ph(16'h0020), 2, 0, 0, 0);

        exp_q.push_back(ph(16'h0010));
        exp_q.push_back(ph(16'h0000));
        run(ph(16'h0010), ph(16'hFFE0), 2, 1, 0, 0);

        exp_q.push_back(ph(16'h12F0));
        exp_q.push_back(ph(16'h12FF));
        run(ph(16'h12F0), ph(16'h0020), 2, 1, 1, 0);

        exp_q.push_back(ph(16'h0F00));
        exp_q.push_back(ph(16'h0000));
        run(ph(16'h0F00), ph(16'h0100), 2, 0, 0, 1);

        // all four lanes at once: plain, positive clamp-free, negative wrap, small
        exp_q.push_back(64'h0004_8000_7FF0_1000);
        exp_q.push_back(64'h0005_0000_8010_1010);
        run(64'h0004_8000_7FF0_1000, 64'h0001_8000_0020_0010, 2, 1, 0, 0);

        // backpressure: first phrase must hold for four stalled cycles
        out_ready = 1'b0;
        exp_q.push_back(ph(16'h1000));
        exp_q.push_back(ph(16'h1010));
        exp_q.push_back(ph(16'h1020));
        start_run(ph(16'h1000), ph(16'h0010), 3, 0, 0, 0, 1'b1);
        for (int k = 0; k < 50 && !out_valid; k++) @(negedge sys_clk);
        repeat (4) begin
            @(negedge sys_clk);
            chk("bp_valid", 64'(out_valid), 1);
            chk("bp_hold", out_data, ph(16'h1000));
        end
        @(posedge sys_clk); #1;
        out_ready = 1'b1;
        wait_done(100);
        chk("bp_hs_count", 64'(hs_cnt), 3);
        chk("bp_queue_empty", 64'(exp_q.size()), 0);

        // zero-length run
        start_run(ph(16'h5555), ph(16'h0001), 0, 0, 0, 0, 1'b1);
        wait_done(20);
        chk("cnt0_done_lat", 64'(done_cyc - start_cyc), 1);
        chk("cnt0_no_valid", 64'(valid_seen), 0);

        // reset in the middle of a run
        for (int k = 0; k < 10; k++) exp_q.push_back(ph(16'h1000 + 16'(k * 16)));
        start_run(ph(16'h1000), ph(16'h0010), 10, 0, 0, 0, 1'b1);
        repeat (3) @(posedge sys_clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_done", 64'(done), 0);
        exp_q.delete();
        @(posedge sys_clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge sys_clk);
        chk("mid_rst_no_done", 64'(done_cnt), 0);

        // accumulator must have been cleared by reset: no acc load here
        exp_q.push_back(ph(16'h0000));
        exp_q.push_back(ph(16'h0003));
        start_run('0, ph(16'h0003), 2, 0, 0, 0, 1'b0);
        wait_done(100);
        chk("post_rst_hs", 64'(hs_cnt), 2);
        chk("post_rst_queue", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gouraud_stepper.md
Name: gouraud_stepper

Overview:
- Blitter-side four-lane phrase accumulator for Gouraud intensity and Z stepping.
- Holds a 64-bit accumulator phrase and a 64-bit increment phrase, each four 16-bit lanes.
- Emits `count` successive phrases: acc, acc+inc, acc+2·inc, … Each add uses per-lane saturating 16-bit addition with eight-bit and high-carry-inhibit modes.
- Feeds the blitter data path (pattern/Z write data) through a valid/ready output register.

Parameters:
- LANES, 4, number of 16-bit lanes; data width = 16·LANES.
- CNT_W, 10, width of the phrase count.

Ports:
- sys_clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- load_acc  in  1  load accumulator from load_data (IDLE only)
- load_inc  in  1  load increment from load_data (IDLE only)
- load_data  in  16·LANES  lane i = bits 16i+15:16i
- start  in  1  begin run (IDLE only)
- count  in  CNT_W  number of phrases to emit, sampled at start
- sat  in  1  saturate enable, sampled at start
- eightbit  in  1  eight-bit lane mode, sampled at start
- hicinh  in  1  inhibit carry bit11→bit12, sampled at start
- busy  out  1  high from accepted start until done pulse inclusive
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_data  out  16·LANES  current phrase
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset clears to IDLE: acc=0, inc=0, out_data=0, out_valid=0, busy=0, done=0, remaining=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - load_acc/load_inc write their registers; both may be asserted in the same cycle.
  - Loads are ignored outside IDLE.
  - Load and start in the same cycle: start uses the pre-load acc/inc values.
- start in IDLE with count≠0:
  - out_data←acc, out_valid←1, acc←step(acc), remaining←count−1, latch modes, go RUN.
  - First phrase is valid the cycle after start.
- start in IDLE with count=0: go DONE, no output.
- RUN, handshake (out_valid & out_ready):
  - remaining>0: out_data←acc, acc←step(acc), remaining−1.
  - remaining=0: out_valid←0, go DONE.
- RUN, no handshake: out_data, acc and remaining hold; out_data stays stable under backpressure.
- DONE: done=1 and busy=1 for one cycle, then IDLE. start during DONE is ignored.
- step() per lane, with a = acc lane and b = inc lane (two's-complement increment):
  - Bits 3:0 carry into 7:4.
  - Carry into bit 8 is gated off when eightbit.
  - Carry into bit 12 is gated off when hicinh.
  - Carry out of bit 15 is ctop16.
  - Top = eightbit ? carry out of bit 7 : ctop16.
  - btop = eightbit ? b[7] : b[15].
  - Saturate when sat & (btop ^ top).
  - When saturating, bits 7:0 become {8{top}}; bits 15:8 also become {8{top}} only when !eightbit.
  - Otherwise the lane takes the wrapped sum.
- Effect: overflow clamps to all ones, underflow clamps to zero. In eightbit mode the high byte adds independently with no saturation.
- Reset mid-run aborts immediately to reset values; no done pulse.

Optional Feature:
- SAT_FLAG_EN defined:
  - Adds output sat_hit [LANES].
  - Per-lane sticky flag set whenever that lane saturates in a step.
  - Cleared on accepted start and on reset.
- Not defined: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (blit_pkg):
  - LANE_W=16
  - state enum {IDLE, RUN, DONE}
  - lane-slice helper constant/function for 16i offsets.
- One sub-module: gstep_lane.
  - Combinational 16-bit saturating lane adder: inputs a, b, sat, eightbit, hicinh; outputs r, satflag.
  - Instantiated LANES times.

Test Plan:
- acc lane0=0x1000, inc=0x0010, count=3, sat=0, out_ready=1 → outputs 0x1000, 0x1010, 0x1020 on consecutive cycles; done the cycle after the third handshake.
- acc=0xFFF0, inc=0x0020, sat=1, count=2 → 0xFFF0, 0xFFFF. With sat=0 → 0xFFF0, 0x0010.
- acc=0x0010, inc=0xFFE0, sat=1, count=2 → 0x0010, 0x0000 (underflow clamp).
- eightbit=1, sat=1, acc=0x12F0, inc=0x0020, count=2 → 0x12F0, 0x12FF. With hicinh=1, eightbit=0, acc=0x0F00, inc=0x0100 → 0x0F00, 0x0000 (bit-12 carry blocked).
- out_ready held low 4 cycles after the first phrase → out_data is stable and acc does not advance. Sequence resumes correctly; total phrase count equals count. count=0 → done one cycle after start, out_valid never high.
- reset asserted mid-RUN → all outputs 0 asynchronously, state IDLE. A subsequent load and start behave normally.
